mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Multi-cycle data-memory responder: the memory end of the CPU's load/store request interface.
- Accepts one read or write request at a time and holds the pipeline with Stall while the access is in flight.
- Signals completion with a one-cycle Done pulse. On a read, DataOut is valid in the same cycle.
- Replaces the single-cycle memory in the MEM stage. The fetch stage may instantiate a second copy as the instruction responder.

Parameters:
- ADDR_W, default 12: byte-address bits used. Storage is 2^(ADDR_W-1) 16-bit words. Higher Addr bits are ignored, so addresses wrap.
- LATENCY, default 4: cycles from request acceptance to Done. Legal range 1..15. LATENCY=0 is illegal and forces err high.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- Addr  in  16  byte address; bit 0 must be 0
- DataIn  in  16  write data
- Rd  in  1  read request
- Wr  in  1  write request
- DataOut  out  16  read data; valid only in the Done cycle of a read, 16'h0000 otherwise
- Done  out  1  one-cycle completion pulse
- Stall  out  1  responder busy; initiator must hold its request and freeze
- err  out  1  sticky illegal-request flag

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter=0.
  - Done=0, Stall=0, DataOut=0, err=0.
  - Storage contents are not reset. An access in flight is aborted and its write is never committed.
- States: IDLE, BUSY, DONE. Encoding is in the package.
- Accept condition: state is IDLE or DONE, and exactly one of Rd/Wr is high, and Addr[0]=0.
- On accept at edge T:
  - Capture Addr[ADDR_W-1:1], DataIn and the op.
  - If LATENCY=1: go to DONE.
  - Otherwise: go to BUSY with counter=LATENCY-1.
- BUSY:
  - Stall=1.
  - Decrement counter each edge. When counter=1, go to DONE at the next edge.
  - Rd/Wr/Addr/DataIn are ignored while BUSY.
- DONE (exactly one cycle, at T+LATENCY):
  - Done=1, Stall=0.
  - Read: DataOut = word at the captured address.
  - Write: the word is committed at the DONE-entry edge, so a read accepted in the DONE cycle sees the new data.
  - Next state: if the accept condition holds, handle it as a new accept (back-to-back, no bubble); otherwise go to IDLE.
- Stall timing:
  - Stall is a Moore output: state==BUSY. It is high for cycles T+1..T+LATENCY-1 and low in the DONE cycle.
  - The initiator must not rely on Stall in the request cycle itself. The pipeline holds its request from T until Done.
- Illegal requests (in IDLE or DONE):
  - Rd and Wr both high → no accept, err set.
  - Addr[0]=1 with Rd or Wr high → no accept, err set.
  - err is cleared only by reset. State is unaffected by an illegal request.
- Rd=Wr=0 in IDLE: stay in IDLE, all outputs 0.
- Address wrap: Addr=16'hFFFE with ADDR_W=12 maps to word 2047.
- Reset asserted in BUSY or DONE: outputs go to 0 immediately; no partial write.

Decomposition:
- Package mem_responder_pkg:
  - state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - counter width constant CNT_W=4
  - LATENCY legality check
- Sub-module mem_resp_array:
  - single-port word storage
  - synchronous write, asynchronous read
  - parameterised by ADDR_W
- The FSM, counter and capture registers stay in mem_responder.

Test Plan:
- Write then read, LATENCY=4:
  - Wr, Addr=16'h0010, DataIn=16'hBEEF at T0 → Stall=1 at T1..T3, Done=1 at T4 only.
  - Rd, Addr=16'h0010 at T4 → Done at T8 with DataOut=16'hBEEF; DataOut=0 at T9.
- LATENCY=1, back-to-back reads of 16'h0000 then 16'h0002 (preloaded 16'h1111/16'h2222):
  - Done at T1 (16'h1111) and T2 (16'h2222).
  - Stall never asserts.
- Request changes while BUSY:
  - Rd 16'h0004 accepted at T0; at T2, Addr changes to 16'h0006 and Wr goes high.
  - Done at T4 returns word 2 (address 16'h0004) only; no write occurs.
- Illegal requests:
  - Rd=Wr=1 in IDLE → err=1 next cycle, state stays IDLE, no Done.
  - After reset, Rd with Addr=16'h0003 → err=1, no Done.
- Reset mid-access:
  - Wr 16'h0020←16'hAAAA accepted; rst=0 for one cycle at T2 → Stall and Done drop immediately.
  - Later read of 16'h0020 returns the prior value, not 16'hAAAA.
- Wrap:
  - Wr to 16'hF002 (ADDR_W=12) with 16'h5A5A, then Rd 16'h0002 → DataOut=16'h5A5A.

Source files
------------

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_pkg                                                    |
// | Shared state encoding, counter width and latency legality check.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package mem_responder_pkg;

   localparam int CNT_W = 4;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t BUSY = 2'd1;
   localparam state_t DONE = 2'd2;

   // The down-counter holds LATENCY-1, so LATENCY must fit in CNT_W bits.
   function automatic logic latency_ok(input int lat);
      return (lat >= 1) && (lat < (1 << CNT_W));
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_resp_array                                                       |
// | 16-bit word storage: synchronous write, asynchronous read.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_resp_array #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-2:0] waddr,
   input  logic [15:0]       wdata,
   input  logic [ADDR_W-2:0] raddr,
   output logic [15:0]       rdata
);

   localparam int c_depth = 2 ** (ADDR_W - 1);

   logic [15:0] r_mem [c_depth];

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder                                                        |
// | Multi-cycle load/store responder with Stall/Done handshake.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        err
);

   localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(1);
   localparam logic             c_lat_bad  = !latency_ok(LATENCY);

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-2:0] r_addr;
   logic [15:0]       r_data;
   logic              r_is_wr;
   logic              r_err;

   logic              w_open;
   logic              w_accept;
   logic              w_illegal;
   logic              w_we;
   logic [ADDR_W-2:0] w_waddr;
   logic [15:0]       w_wdata;
   logic [15:0]       w_rdata;

   assign w_open    = (r_state == IDLE) || (r_state == DONE);
   assign w_accept  = w_open && (Rd ^ Wr) && !Addr[0];
   assign w_illegal = w_open && (Rd || Wr) && ((Rd && Wr) || Addr[0]);

   generate
      if (ADDR_W < 16) begin : g_addr_hi
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^Addr[15:ADDR_W];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_accept) begin
               w_next = (LATENCY <= 1) ? DONE : BUSY;
            end else begin
               w_next = IDLE;
            end
         end
         BUSY: begin
            if (r_cnt <= c_cnt_last) begin
               w_next = DONE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_is_wr <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= Addr[ADDR_W-1:1];
            r_data  <= DataIn;
            r_is_wr <= Wr;
            r_cnt   <= c_cnt_init;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_illegal) begin
            r_err <= 1'b1;
         end
      end
   end

   // Commit on the edge entering DONE; with LATENCY=1 that is the accept
   // edge itself, so the live request feeds the write port directly.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = Addr[ADDR_W-1:1];
      w_wdata = DataIn;
      if (r_state == BUSY) begin
         w_waddr = r_addr;
         w_wdata = r_data;
         w_we    = r_is_wr;
      end else begin
         w_we    = Wr;
      end
      w_we = w_we && rst && (w_next == DONE);
   end

   mem_resp_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (w_wdata),
      .raddr (r_addr),
      .rdata (w_rdata)
   );

   always_comb begin
      Stall   = (r_state == BUSY);
      Done    = (r_state == DONE);
      DataOut = '0;
      if ((r_state == DONE) && !r_is_wr) begin
         DataOut = w_rdata;
      end
      err = r_err || c_lat_bad;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_responder                                                     |
// | Self-checking bench: LATENCY=4, LATENCY=1 and LATENCY=0 instances.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mem_responder;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr4, din4, addr1, din1;
   logic        rd4, wr4, rd1, wr1;
   logic [15:0] dout4, dout1, dout0;
   logic        done4, stall4, err4;
   logic        done1, stall1, err1;
   logic        done0, stall0, err0;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] sb[$];
   bit          stall1_seen = 1'b0;
   vec_t        tbl[10];

   always #5 clk = ~clk;

   mem_responder #(.ADDR_W(12), .LATENCY(4)) dut4 (
      .clk(clk), .rst(rst), .Addr(addr4), .DataIn(din4), .Rd(rd4), .Wr(wr4),
      .DataOut(dout4), .Done(done4), .Stall(stall4), .err(err4)
   );

   mem_responder #(.ADDR_W(12), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .Addr(addr1), .DataIn(din1), .Rd(rd1), .Wr(wr1),
      .DataOut(dout1), .Done(done1), .Stall(stall1), .err(err1)
   );

   mem_responder #(.ADDR_W(12), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .Addr(16'h0000), .DataIn(16'h0000), .Rd(1'b0), .Wr(1'b0),
      .DataOut(dout0), .Done(done0), .Stall(stall0), .err(err0)
   );

   always @(negedge clk) begin
      if (rst && stall1) stall1_seen = 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit l1, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] d);
      if (l1) begin
         rd1 = rd; wr1 = wr; addr1 = a; din1 = d;
      end else begin
         rd4 = rd; wr4 = wr; addr4 = a; din4 = d;
      end
   endtask

   // Called at a negedge of an IDLE or DONE cycle; returns at the Done negedge
   // with the request lines idle so the caller may chain another request.
   task automatic run_txn(input bit l1, input bit rd, input bit wr,
                          input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp, input string tag);
      int lat;
      int cyc;
      bit seen;
      lat  = l1 ? 1 : 4;
      cyc  = 0;
      seen = 1'b0;
      drive(l1, rd, wr, a, d);
      if (rd) sb.push_back(exp);
      while (!seen && cyc < lat + 6) begin
         @(negedge clk);
         cyc++;
         if (l1 ? done1 : done4) begin
            seen = 1'b1;
            check({tag, " latency"}, cyc, lat);
            check({tag, " stall_in_done"}, l1 ? stall1 : stall4, 0);
            if (rd) check({tag, " data"}, l1 ? dout1 : dout4, sb.pop_front());
            else    check({tag, " dout_on_write"}, l1 ? dout1 : dout4, 0);
         end else begin
            check({tag, " stall_busy"}, l1 ? stall1 : stall4, 1);
         end
      end
      if (!seen) begin
         check({tag, " done_timeout"}, 0, 1);
         if (rd) void'(sb.pop_back());
      end
      drive(l1, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got_done;

      tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
      tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
      tbl[2] = '{1'b0, 1'b1, 16'hF002, 16'h5A5A, 16'h0000};
      tbl[3] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h5A5A};
      tbl[4] = '{1'b0, 1'b1, 16'hFFFE, 16'h1234, 16'h0000};
      tbl[5] = '{1'b1, 1'b0, 16'h0FFE, 16'h0000, 16'h1234};
      tbl[6] = '{1'b0, 1'b1, 16'h0004, 16'hC0DE, 16'h0000};
      tbl[7] = '{1'b0, 1'b1, 16'h0006, 16'h1357, 16'h0000};
      tbl[8] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'hC0DE};
      tbl[9] = '{1'b1, 1'b0, 16'h0006, 16'h0000, 16'h1357};

      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #1;
      check("reset done", done4, 0);
      check("reset stall", stall4, 0);
      check("reset dout", dout4, 0);
      check("reset err", err4, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("idle outputs", {done4, stall4, err4, dout4}, 0);
      check("latency0 err", err0, 1);

      // LATENCY=4 table, each request issued in the previous Done cycle
      for (int i = 0; i < 10; i++) begin
         run_txn(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].exp,
                 $sformatf("tbl%0d", i));
      end
      @(negedge clk);
      check("dout after done", dout4, 0);
      check("done after done", done4, 0);
      check("err after table", err4, 0);

      // LATENCY=1 back-to-back writes and reads
      run_txn(1'b1, 1'b0, 1'b1, 16'h0000, 16'h1111, 16'h0000, "l1 wr0");
      run_txn(1'b1, 1'b0, 1'b1, 16'h0002, 16'h2222, 16'h0000, "l1 wr2");
      run_txn(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111, "l1 rd0");
      run_txn(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2222, "l1 rd2");
      run_txn(1'b1, 1'b0, 1'b1, 16'h0004, 16'hABCD, 16'h0000, "l1 wr4");
      run_txn(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000, 16'hABCD, "l1 rd4");
      check("l1 stall never", stall1_seen, 0);
      check("l1 err", err1, 0);

      // Request changed while BUSY must be ignored
      drive(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
      sb.push_back(16'hC0DE);
      @(negedge clk);
      check("busy chg stall T1", stall4, 1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 16'h0006, 16'hDEAD);
      @(negedge clk);
      check("busy chg stall T3", stall4, 1);
      @(negedge clk);
      check("busy chg done T4", done4, 1);
      check("busy chg data", dout4, sb.pop_front());
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      run_txn(1'b0, 1'b1, 1'b0, 16'h0006, 16'h0000, 16'h1357, "busy chg nowrite");
      check("busy chg err", err4, 0);

      // Illegal: Rd and Wr together
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
      @(negedge clk);
      check("rdwr err", err4, 1);
      check("rdwr stall", stall4, 0);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      got_done = done4;
      repeat (5) begin
         @(negedge clk);
         got_done |= done4;
      end
      check("rdwr no done", got_done, 0);

      @(posedge clk);
      #1 rst = 1'b0;
      #1 check("err cleared by reset", err4, 0);
      @(negedge clk);
      rst = 1'b1;

      // Illegal: odd address
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
      @(negedge clk);
      check("odd err", err4, 1);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      got_done = done4 | stall4;
      repeat (5) begin
         @(negedge clk);
         got_done |= done4 | stall4;
      end
      check("odd no access", got_done, 0);

      // Reset in the middle of a write
      run_txn(1'b0, 1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0000, "pre wr20");
      drive(1'b0, 1'b0, 1'b1, 16'h0020, 16'hAAAA);
      @(negedge clk);
      check("abort stall T1", stall4, 1);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 check("abort outputs", {done4, stall4, dout4}, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      got_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         got_done |= done4 | stall4;
      end
      check("abort quiet", got_done, 0);
      run_txn(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1111, "abort rd20");

      check("scoreboard empty", sb.size(), 0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
